// File: rtl/line_dispatch_ctrl_if.sv
// Handshake bundle between the command source, the line dispatcher and the rasterizer.
// slave is the dispatcher's view; master is the command source / rasterizer side.
interface line_dispatch_ctrl_if #(
  parameter int CW = 13
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic signed [CW-1:0] cmd_sx, cmd_sy, cmd_ex, cmd_ey;
  logic [3:0]           cmd_color;

  logic                 rast_ready;
  logic                 rast_done;
  logic                 rast_start;
  logic signed [CW-1:0] rast_sx, rast_sy, rast_ex, rast_ey;
  logic [3:0]           rast_color;

  modport slave (
    input  cmd_valid, cmd_sx, cmd_sy, cmd_ex, cmd_ey, cmd_color,
    input  rast_ready, rast_done,
    output cmd_ready,
    output rast_start, rast_sx, rast_sy, rast_ex, rast_ey, rast_color
  );

  modport master (
    output cmd_valid, cmd_sx, cmd_sy, cmd_ex, cmd_ey, cmd_color,
    output rast_ready, rast_done,
    input  cmd_ready,
    input  rast_start, rast_sx, rast_sy, rast_ex, rast_ey, rast_color
  );
endinterface

// File: rtl/line_dispatch_ctrl.sv
// Buffers line commands and issues them one at a time to the rasterizer, with
// frame tracking (lines per frame) and a watchdog against a hung rasterizer.
module line_dispatch_ctrl #(
  parameter int DEPTH   = 16,
  parameter int CW      = 13,
  parameter int TIMEOUT = 4095
) (
  input  logic                   clk,
  input  logic                   rst,
  line_dispatch_ctrl_if.slave    bus,
  input  logic                   frame_end,
  output logic                   frame_done,
  output logic [15:0]            lines_last,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   timeout_err
);
  localparam int          AW       = $clog2(DEPTH);
  localparam int          EW       = 4 + 4 * CW;
  localparam logic [AW:0] FULL     = (AW + 1)'(DEPTH);
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;
  state_t state, state_next;

  logic [EW-1:0]        mem [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic [EW-1:0]        head;
  logic                 push, pop, line_ok, wd_expire;
  logic [15:0]          wd, line_cnt, line_cnt_next;
  logic                 frame_pend, frame_fire;
  logic signed [CW-1:0] sx_q, sy_q, ex_q, ey_q;
  logic [3:0]           color_q;

  // cmd_ready comes from the registered count, so a pop cannot open a slot the same cycle.
  assign bus.cmd_ready  = (count != FULL);
  assign push           = bus.cmd_valid && bus.cmd_ready;
  assign head           = mem[rd_ptr];
  assign fifo_count     = count;
  assign bus.rast_start = (state == ISSUE);
  assign bus.rast_sx    = sx_q;
  assign bus.rast_sy    = sy_q;
  assign bus.rast_ex    = ex_q;
  assign bus.rast_ey    = ey_q;
  assign bus.rast_color = color_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next = state;
    pop        = 1'b0;
    line_ok    = 1'b0;
    wd_expire  = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0 && bus.rast_ready) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (bus.rast_done) begin
          line_ok    = 1'b1;
          state_next = IDLE;
        end else if (wd == WD_LIMIT) begin
          wd_expire  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign line_cnt_next = (line_ok && line_cnt != 16'hFFFF) ? line_cnt + 16'd1 : line_cnt;
  // A push in the same cycle means the frame is not yet drained; hold the pulse.
  assign frame_fire    = frame_pend && count == '0 && state == IDLE && !push;
  assign frame_done    = frame_fire;

  // NOTE: the storage array is not reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.cmd_color, bus.cmd_sx, bus.cmd_sy, bus.cmd_ex, bus.cmd_ey};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      wd          <= '0;
      line_cnt    <= '0;
      lines_last  <= '0;
      frame_pend  <= 1'b0;
      timeout_err <= 1'b0;
      sx_q        <= '0;
      sy_q        <= '0;
      ex_q        <= '0;
      ey_q        <= '0;
      color_q     <= '0;
    end else begin
      state <= state_next;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        {color_q, sx_q, sy_q, ex_q, ey_q} <= head;
      end
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase

      if (state == ISSUE) wd <= '0;
      else if (state == WAIT_DONE && !bus.rast_done && !wd_expire) wd <= wd + 16'd1;
      if (wd_expire) timeout_err <= 1'b1;

      if (frame_fire) begin
        lines_last <= line_cnt_next;
        line_cnt   <= '0;
      end else begin
        line_cnt   <= line_cnt_next;
      end
      // A frame_end arriving while one is pending merges into the same frame_done.
      frame_pend <= frame_end || (frame_pend && !frame_fire);
    end
  end
endmodule

// File: tb/tb_line_dispatch_ctrl.sv
// Scoreboard bench for line_dispatch_ctrl with a behavioural rasterizer model.
// Accepted commands go to exp_q; issued lines are captured into obs_q and compared in order.
module tb_line_dispatch_ctrl;
  localparam int          DEPTH   = 16;
  localparam int          CW      = 13;
  localparam int          TIMEOUT = 100;
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] FULL    = (AW + 1)'(DEPTH);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_end = 1'b0;
  logic        frame_done, timeout_err;
  logic [15:0] lines_last;
  logic [AW:0] fifo_count;

  line_dispatch_ctrl_if #(.CW(CW)) bus();

  line_dispatch_ctrl #(.DEPTH(DEPTH), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .frame_end  (frame_end),
    .frame_done (frame_done),
    .lines_last (lines_last),
    .fifo_count (fifo_count),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [55:0] exp_q[$];
  logic [55:0] obs_q[$];
  int          push_cyc_q[$];
  int          start_cyc_q[$];
  int          done_cyc_q[$];
  int          fd_cyc_q[$];

  // Rasterizer model: busy from start until the cycle after its done pulse; a hung
  // model never answers and is released when the dispatcher's watchdog fires.
  int   done_lat = 4;
  bit   ready_en = 1'b0;
  bit   hang = 1'b0;
  bit   busy = 1'b0;
  bit   in_done = 1'b0;
  int   lat = 0;
  logic to_prev = 1'b0;

  always @(posedge clk) begin
    #2;
    bus.rast_done = 1'b0;
    if (rst) begin
      busy    = 1'b0;
      in_done = 1'b0;
      to_prev = 1'b0;
    end else begin
      if (in_done) begin
        busy    = 1'b0;
        in_done = 1'b0;
      end
      if (timeout_err && !to_prev) busy = 1'b0;
      to_prev = timeout_err;
      if (bus.rast_start) begin
        busy = 1'b1;
        lat  = done_lat;
      end else if (busy && !hang && !in_done) begin
        lat = lat - 1;
        if (lat == 0) begin
          bus.rast_done = 1'b1;
          in_done       = 1'b1;
        end
      end
    end
    bus.rast_ready = ready_en && !busy;
  end

  function automatic logic [55:0] pack(input logic [3:0] c, input logic [12:0] sx, sy, ex, ey);
    return {c, sx, sy, ex, ey};
  endfunction

  function automatic logic [55:0] gen(input int i);
    return {4'(i), 13'(i * 3), 13'(-i), 13'(i + 100), 13'(i ^ 5)};
  endfunction

  task automatic drive_cmd(input logic [55:0] w);
    {bus.cmd_color, bus.cmd_sx, bus.cmd_sy, bus.cmd_ex, bus.cmd_ey} = w;
    bus.cmd_valid = 1'b1;
  endtask

  // One clock: record events at the falling edge, return 1ns after the next rising edge.
  task automatic step();
    @(negedge clk);
    if (bus.cmd_valid && bus.cmd_ready) begin
      exp_q.push_back({bus.cmd_color, bus.cmd_sx, bus.cmd_sy, bus.cmd_ex, bus.cmd_ey});
      push_cyc_q.push_back(cyc);
    end
    if (bus.rast_start) begin
      obs_q.push_back({bus.rast_color, bus.rast_sx, bus.rast_sy, bus.rast_ex, bus.rast_ey});
      start_cyc_q.push_back(cyc);
    end
    if (bus.rast_done) done_cyc_q.push_back(cyc);
    if (frame_done) fd_cyc_q.push_back(cyc);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    frame_end = 1'b0;
    hang = 1'b0;
    ready_en = 1'b0;
    run(2);
    rst = 1'b0;
    exp_q.delete(); obs_q.delete(); push_cyc_q.delete();
    start_cyc_q.delete(); done_cyc_q.delete(); fd_cyc_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (fifo_count !== '0) begin failures++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
    checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b want=1", bus.cmd_ready); end
    checks++; if ({bus.rast_start, frame_done, timeout_err} !== 3'b000) begin
      failures++; $display("FAIL reset_pulses got=%b want=000", {bus.rast_start, frame_done, timeout_err}); end
    checks++; if ({lines_last, bus.rast_color, bus.rast_sx, bus.rast_sy, bus.rast_ex, bus.rast_ey} !== '0) begin
      failures++; $display("FAIL reset_regs lines_last=%0d rast_sx=%0d want all 0", lines_last, bus.rast_sx); end
    ready_en = 1'b1;
    run(5);
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL reset_no_start got=%0d starts want=0", obs_q.size()); end
  endtask

  task automatic test_single_line();
    logic [55:0] got, want;
    do_reset();
    ready_en = 1'b1; done_lat = 4;
    drive_cmd(pack(4'd7, -13'sd25, 13'sd50, 13'sd75, 13'sd250));
    step();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 20 && obs_q.size() == 0; i++) step();
    checks++;
    if (obs_q.size() == 0 || exp_q.size() == 0) begin
      failures++; $display("FAIL single_start got=none within 20 cycles want=1"); return;
    end
    got = obs_q.pop_front(); want = exp_q.pop_front();
    checks++; if (got !== want) begin failures++; $display("FAIL single_data got=%h want=%h", got, want); end
    checks++; if (start_cyc_q[0] - push_cyc_q[0] != 2) begin
      failures++; $display("FAIL single_latency got=%0d want=2", start_cyc_q[0] - push_cyc_q[0]); end
    run(8);
    checks++; if (bus.rast_sx !== -13'sd25 || bus.rast_ey !== 13'sd250) begin
      failures++; $display("FAIL single_hold got sx=%0d ey=%0d want -25 250", bus.rast_sx, bus.rast_ey); end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL single_extra got=%0d starts want=0", obs_q.size()); end
    frame_end = 1'b1; step(); frame_end = 1'b0;
    run(3);
    checks++; if (fd_cyc_q.size() != 1) begin failures++; $display("FAIL single_frame got=%0d want=1", fd_cyc_q.size()); end
    checks++; if (lines_last !== 16'd1) begin failures++; $display("FAIL single_lines got=%0d want=1", lines_last); end
  endtask

  task automatic test_fill();
    logic [55:0] got, want;
    do_reset();
    ready_en = 1'b0; done_lat = 4;
    for (int i = 0; i < 20; i++) begin
      drive_cmd(pack(4'(i), 13'($urandom), 13'($urandom), 13'($urandom), 13'(i)));
      step();
    end
    bus.cmd_valid = 1'b0;
    checks++; if (exp_q.size() != DEPTH) begin failures++; $display("FAIL fill_accepted got=%0d want=%0d", exp_q.size(), DEPTH); end
    checks++; if (fifo_count !== FULL) begin failures++; $display("FAIL fill_count got=%0d want=%0d", fifo_count, DEPTH); end
    checks++; if (bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL fill_ready got=%b want=0", bus.cmd_ready); end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL fill_no_start got=%0d want=0", obs_q.size()); end
    ready_en = 1'b1;
    for (int n = 0; n < 300 && start_cyc_q.size() < DEPTH; n++) step();
    run(10);
    checks++; if (start_cyc_q.size() != DEPTH) begin failures++; $display("FAIL fill_starts got=%0d want=%0d", start_cyc_q.size(), DEPTH); end
    for (int i = 0; i < DEPTH && obs_q.size() != 0 && exp_q.size() != 0; i++) begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      checks++; if (got !== want) begin failures++; $display("FAIL fill_data[%0d] got=%h want=%h", i, got, want); end
      if (i > 0) begin
        checks++;
        if (i - 1 >= done_cyc_q.size() || start_cyc_q[i] <= done_cyc_q[i-1]) begin
          failures++; $display("FAIL fill_order[%0d] start=%0d not after prior done", i, start_cyc_q[i]); end
      end
    end
  endtask

  task automatic test_frame();
    logic [55:0] got, want;
    int f;
    do_reset();
    ready_en = 1'b1; done_lat = 4;
    for (int i = 0; i < 3; i++) begin drive_cmd(gen(i + 40)); step(); end
    bus.cmd_valid = 1'b0;
    frame_end = 1'b1; step(); frame_end = 1'b0;
    step();
    frame_end = 1'b1; step(); frame_end = 1'b0;
    for (int n = 0; n < 200 && fd_cyc_q.size() == 0; n++) step();
    run(10);
    checks++; if (fd_cyc_q.size() != 1) begin failures++; $display("FAIL frame_pulses got=%0d want=1", fd_cyc_q.size()); end
    checks++;
    if (done_cyc_q.size() != 3 || fd_cyc_q.size() == 0 || fd_cyc_q[0] != done_cyc_q[2] + 1) begin
      failures++; $display("FAIL frame_timing dones=%0d frame_done not 1 cycle after 3rd done", done_cyc_q.size()); end
    checks++; if (lines_last !== 16'd3) begin failures++; $display("FAIL frame_lines got=%0d want=3", lines_last); end
    for (int i = 0; i < 3 && obs_q.size() != 0 && exp_q.size() != 0; i++) begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      checks++; if (got !== want) begin failures++; $display("FAIL frame_data[%0d] got=%h want=%h", i, got, want); end
    end
    fd_cyc_q.delete();
    f = cyc;
    frame_end = 1'b1; step(); frame_end = 1'b0;
    run(4);
    checks++; if (fd_cyc_q.size() != 1 || fd_cyc_q[0] != f + 1) begin
      failures++; $display("FAIL empty_frame pulses=%0d want 1 at cycle %0d", fd_cyc_q.size(), f + 1); end
    checks++; if (lines_last !== 16'd0) begin failures++; $display("FAIL empty_frame_lines got=%0d want=0", lines_last); end
  endtask

  task automatic test_timeout();
    int to_cyc;
    logic [55:0] want;
    do_reset();
    ready_en = 1'b1; hang = 1'b1;
    for (int i = 0; i < 2; i++) begin drive_cmd(gen(i + 70)); step(); end
    bus.cmd_valid = 1'b0;
    to_cyc = -1;
    for (int n = 0; n < 400; n++) begin
      step();
      if (timeout_err) begin to_cyc = cyc; break; end
    end
    hang = 1'b0;
    checks++;
    if (to_cyc < 0 || start_cyc_q.size() == 0) begin
      failures++; $display("FAIL timeout_flag got=none within 400 cycles want=set"); return;
    end
    // Watchdog reaches TIMEOUT in the 101st WAIT_DONE cycle; the flag is visible the cycle after.
    checks++; if (to_cyc - start_cyc_q[0] != TIMEOUT + 2) begin
      failures++; $display("FAIL timeout_latency got=%0d want=%0d", to_cyc - start_cyc_q[0], TIMEOUT + 2); end
    for (int n = 0; n < 50 && start_cyc_q.size() < 2; n++) step();
    run(10);
    checks++;
    if (start_cyc_q.size() != 2 || obs_q.size() != 2 || exp_q.size() != 2) begin
      failures++; $display("FAIL timeout_next got=%0d starts want=2", start_cyc_q.size()); return;
    end
    want = exp_q[1];
    checks++; if (obs_q[1] !== want || start_cyc_q[1] != to_cyc + 1) begin
      failures++; $display("FAIL timeout_next_issue got=%h@%0d want=%h@%0d", obs_q[1], start_cyc_q[1], want, to_cyc + 1); end
    frame_end = 1'b1; step(); frame_end = 1'b0;
    run(3);
    checks++; if (lines_last !== 16'd1) begin failures++; $display("FAIL timeout_not_counted got=%0d want=1", lines_last); end
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_sticky got=%b want=1", timeout_err); end
  endtask

  task automatic test_back_to_back();
    int n, bad;
    logic [55:0] got, want;
    do_reset();
    ready_en = 1'b0; done_lat = 1;
    n = 0; bad = 0;
    drive_cmd(gen(0));
    for (int i = 0; i < 140; i++) begin
      if (i == 20) ready_en = 1'b1;
      step();
      if (push_cyc_q.size() > n) begin n = push_cyc_q.size(); drive_cmd(gen(n)); end
      if (i >= 20 && (fifo_count < FULL - 1 || fifo_count > FULL)) bad++;
    end
    bus.cmd_valid = 1'b0;
    checks++; if (bad != 0) begin failures++; $display("FAIL stream_count got=%0d out-of-range cycles want=0", bad); end
    checks++; if (n <= DEPTH + 30) begin failures++; $display("FAIL stream_progress got=%0d accepted want>%0d", n, DEPTH + 30); end
    for (int k = 0; k < 400 && start_cyc_q.size() < n; k++) step();
    run(5);
    checks++; if (start_cyc_q.size() != n) begin failures++; $display("FAIL stream_total got=%0d want=%0d", start_cyc_q.size(), n); end
    while (obs_q.size() != 0 && exp_q.size() != 0) begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      checks++; if (got !== want) begin failures++; $display("FAIL stream_order got=%h want=%h", got, want); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ready_en = 1'b1; hang = 1'b1;
    for (int i = 0; i < 7; i++) begin drive_cmd(gen(i + 90)); step(); end
    bus.cmd_valid = 1'b0;
    for (int n = 0; n < 300 && start_cyc_q.size() < 2; n++) step();
    run(3);
    checks++; if (fifo_count !== 5'd5 || timeout_err !== 1'b1) begin
      failures++; $display("FAIL midrst_setup count=%0d err=%b want 5 1", fifo_count, timeout_err); end
    frame_end = 1'b1; step(); frame_end = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    hang = 1'b0;
    checks++; if (fifo_count !== '0) begin failures++; $display("FAIL midrst_count got=%0d want=0", fifo_count); end
    checks++; if ({bus.rast_start, frame_done, timeout_err} !== 3'b000) begin
      failures++; $display("FAIL midrst_outputs got=%b want=000", {bus.rast_start, frame_done, timeout_err}); end
    obs_q.delete();
    run(6);
    checks++; if (obs_q.size() != 0 || bus.cmd_ready !== 1'b1 || fd_cyc_q.size() != 0) begin
      failures++; $display("FAIL midrst_quiet starts=%0d ready=%b frames=%0d want 0 1 0", obs_q.size(), bus.cmd_ready, fd_cyc_q.size()); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bus.cmd_valid = 1'b0;
    {bus.cmd_color, bus.cmd_sx, bus.cmd_sy, bus.cmd_ex, bus.cmd_ey} = '0;
    test_reset();
    test_single_line();
    test_fill();
    test_frame();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
